// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared quadrature-encoder types, direction decode and the
//                default sample divider.
//  Revision    : 1.0
// ============================================================================
package enc_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_state_t;

    typedef enum logic [1:0] {
        QD_NONE = 2'd0,
        QD_UP   = 2'd1,
        QD_DOWN = 2'd2,
        QD_ERR  = 2'd3
    } quad_dir_t;

    localparam int c_SAMPLE_DIV_DEFAULT = 1_000_000;

    // Position around the clockwise cycle Q00->Q01->Q11->Q10
    function automatic logic [1:0] quad_pos(input logic [1:0] s);
        logic [1:0] w_pos;
        case (s)
            Q00:     w_pos = 2'd0;
            Q01:     w_pos = 2'd1;
            Q11:     w_pos = 2'd2;
            default: w_pos = 2'd3;
        endcase
        return w_pos;
    endfunction

    function automatic quad_dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] w_delta;
        quad_dir_t  w_dir;
        w_delta = quad_pos(cur) - quad_pos(prev);
        case (w_delta)
            2'd0:    w_dir = QD_NONE;
            2'd1:    w_dir = QD_UP;
            2'd3:    w_dir = QD_DOWN;
            default: w_dir = QD_ERR;
        endcase
        return w_dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : enc_debounce
//  Description : Encoder synchroniser, sample tick and two-sample stability
//                check. stable_vld pulses on a tick whose sample matches the
//                previous tick's sample.
//  Revision    : 1.0
// ============================================================================
module enc_debounce
    import enc_pkg::*;
#(
    parameter int SAMPLE_DIV = c_SAMPLE_DIV_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] encoder,
    output logic       tick,
    output logic [1:0] stable,
    output logic       stable_vld
);

    localparam int c_CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_smp;
    logic               w_tick;

    assign w_tick = (r_cnt == c_CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_smp   <= 2'b00;
        end else begin
            r_sync1 <= encoder;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_cnt <= '0;
                r_smp <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tick       = w_tick;
    assign stable     = r_sync2;
    assign stable_vld = w_tick && (r_sync2 == r_smp);

endmodule
`default_nettype wire

// File: rtl/quad_encoder_bank.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_bank
//  Description : Debounced quadrature encoder stepping one of NREGS operand
//                registers, with wrap/saturate, clear, error and step pulses.
//  Revision    : 1.0
// ============================================================================
module quad_encoder_bank
    import enc_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int NREGS      = 2,
    parameter int SAMPLE_DIV = c_SAMPLE_DIV_DEFAULT,
    parameter int QDIV       = 1,
    parameter int SATURATE   = 0,
    parameter int SEL_W      = $clog2(NREGS)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             ENCODER,
    input  logic [SEL_W-1:0]       REG_SEL,
    input  logic                   CLR,
    output logic [NREGS*WIDTH-1:0] VALUES,
    output logic                   STEP,
    output logic                   DIR_UP,
    output logic                   ENC_ERR,
    output logic [NREGS-1:0]       LED_SEL
);

    localparam logic signed [3:0] c_QDIV = QDIV[3:0];

    logic                    w_tick;
    logic [1:0]              w_stable;
    logic                    w_stable_vld;
    quad_dir_t               w_dir;
    logic signed [3:0]       w_acc_next;
    logic                    w_cnt_up;
    logic                    w_cnt_dn;
    logic                    w_err;
    logic                    w_sel_ok;
    logic [WIDTH-1:0]        w_cur;
    logic [WIDTH-1:0]        w_new;
    logic [NREGS-1:0]        w_led;

    logic [WIDTH-1:0]        r_vals [NREGS];
    logic signed [3:0]       r_acc;
    logic [1:0]              r_prev;
    logic                    r_prev_valid;
    logic                    r_step;
    logic                    r_dir_up;
    logic                    r_err;
    logic [NREGS-1:0]        r_led;

    enc_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_debounce (
        .CLK        (CLK),
        .RST        (RST),
        .encoder    (ENCODER),
        .tick       (w_tick),
        .stable     (w_stable),
        .stable_vld (w_stable_vld)
    );

    assign w_sel_ok = (32'(REG_SEL) < NREGS);

    always_comb begin
        w_dir      = quad_dir(r_prev, w_stable);
        w_acc_next = r_acc;
        w_cnt_up   = 1'b0;
        w_cnt_dn   = 1'b0;
        w_err      = 1'b0;
        if (w_stable_vld && r_prev_valid) begin
            case (w_dir)
                QD_UP:   w_acc_next = r_acc + 4'sd1;
                QD_DOWN: w_acc_next = r_acc - 4'sd1;
                QD_ERR: begin
                    w_err      = 1'b1;
                    w_acc_next = '0;
                end
                default: w_acc_next = r_acc;
            endcase
        end
        // A full detent consumes the accumulator
        if (w_acc_next == c_QDIV) begin
            w_cnt_up   = 1'b1;
            w_acc_next = '0;
        end else if (w_acc_next == -c_QDIV) begin
            w_cnt_dn   = 1'b1;
            w_acc_next = '0;
        end

        w_cur = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (REG_SEL == SEL_W'(k)) w_cur = r_vals[k];
        end

        w_new = w_cur;
        if (w_cnt_up) begin
            if (!((SATURATE != 0) && (w_cur == {WIDTH{1'b1}}))) w_new = w_cur + 1'b1;
        end else if (w_cnt_dn) begin
            if (!((SATURATE != 0) && (w_cur == '0))) w_new = w_cur - 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NREGS; k++) begin : g_led
            assign w_led[k] = (REG_SEL == SEL_W'(k));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NREGS; k++) r_vals[k] <= '0;
            r_acc        <= '0;
            r_prev       <= 2'b00;
            r_prev_valid <= 1'b0;
            r_step       <= 1'b0;
            r_dir_up     <= 1'b0;
            r_err        <= 1'b0;
            r_led        <= '0;
        end else begin
            r_led  <= w_led;
            r_step <= 1'b0;
            r_err  <= w_err;
            if (w_tick) r_acc <= CLR ? 4'sd0 : w_acc_next;
            if (w_stable_vld) begin
                r_prev       <= w_stable;
                r_prev_valid <= 1'b1;
            end
            // Clear takes priority over a coincident count
            for (int k = 0; k < NREGS; k++) begin
                if (w_tick && (REG_SEL == SEL_W'(k))) begin
                    if (CLR) r_vals[k] <= '0;
                    else if (w_cnt_up || w_cnt_dn) r_vals[k] <= w_new;
                end
            end
            if (w_tick && !CLR && w_sel_ok && (w_cnt_up || w_cnt_dn)) begin
                r_dir_up <= w_cnt_up;
                r_step   <= (w_new != w_cur);
            end
        end
    end

    generate
        for (genvar k = 0; k < NREGS; k++) begin : g_pack
            assign VALUES[k*WIDTH +: WIDTH] = r_vals[k];
        end
    endgenerate

    assign STEP    = r_step;
    assign DIR_UP  = r_dir_up;
    assign ENC_ERR = r_err;
    assign LED_SEL = r_led;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_encoder_bank
//  Description : Self-checking bench for three builds (wrap QDIV=1, wrap
//                QDIV=4, saturate QDIV=1) driven by the same encoder stimulus.
//  Revision    : 1.0
// ============================================================================
module tb_quad_encoder_bank;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int SD = 4;
    localparam int ND = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] ENCODER = 2'b00;
    logic [1:0] REG_SEL = 2'd1;
    logic       CLR = 1'b0;

    logic [N*W-1:0] dv    [ND];
    logic           dstep [ND];
    logic           ddir  [ND];
    logic           derr  [ND];
    logic [N-1:0]   dled  [ND];

    always #5 CLK = ~CLK;

    quad_encoder_bank #(.WIDTH(W), .NREGS(N), .SAMPLE_DIV(SD), .QDIV(1), .SATURATE(0)) u_q1 (
        .CLK(CLK), .RST(RST), .ENCODER(ENCODER), .REG_SEL(REG_SEL), .CLR(CLR),
        .VALUES(dv[0]), .STEP(dstep[0]), .DIR_UP(ddir[0]), .ENC_ERR(derr[0]), .LED_SEL(dled[0]));
    quad_encoder_bank #(.WIDTH(W), .NREGS(N), .SAMPLE_DIV(SD), .QDIV(4), .SATURATE(0)) u_q4 (
        .CLK(CLK), .RST(RST), .ENCODER(ENCODER), .REG_SEL(REG_SEL), .CLR(CLR),
        .VALUES(dv[1]), .STEP(dstep[1]), .DIR_UP(ddir[1]), .ENC_ERR(derr[1]), .LED_SEL(dled[1]));
    quad_encoder_bank #(.WIDTH(W), .NREGS(N), .SAMPLE_DIV(SD), .QDIV(1), .SATURATE(1)) u_sat (
        .CLK(CLK), .RST(RST), .ENCODER(ENCODER), .REG_SEL(REG_SEL), .CLR(CLR),
        .VALUES(dv[2]), .STEP(dstep[2]), .DIR_UP(ddir[2]), .ENC_ERR(derr[2]), .LED_SEL(dled[2]));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per build, position arithmetic on debounced samples
    int         QD  [ND] = '{1, 4, 1};
    int         SAT [ND] = '{0, 0, 1};
    int         m_cnt;
    logic [1:0] m_d1, m_d2, m_smp, m_s2;
    bit         m_tick, m_stab;
    int         m_val  [ND][N];
    int         m_acc  [ND];
    bit         m_pv   [ND];
    logic [1:0] m_prev [ND];
    bit         m_step [ND];
    bit         m_err  [ND];
    bit         m_dir  [ND];
    logic [N-1:0] m_led [ND];
    int         m_cd, m_sel, m_d, m_nv;

    function automatic int pos_of(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] code_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    initial forever begin
        @(posedge CLK);
        if (RST) begin
            m_cnt = 0; m_d1 = 0; m_d2 = 0; m_smp = 0;
            for (int k = 0; k < ND; k++) begin
                for (int j = 0; j < N; j++) m_val[k][j] = 0;
                m_acc[k] = 0; m_pv[k] = 0; m_prev[k] = 0;
                m_step[k] = 0; m_err[k] = 0; m_dir[k] = 0; m_led[k] = '0;
            end
        end else begin
            m_tick = (m_cnt == SD - 1);
            m_cnt  = m_tick ? 0 : m_cnt + 1;
            m_s2   = m_d2;
            m_d2   = m_d1;
            m_d1   = ENCODER;
            m_sel  = int'(REG_SEL);
            m_stab = 0;
            if (m_tick) begin
                m_stab = (m_s2 == m_smp);
                m_smp  = m_s2;
            end
            for (int k = 0; k < ND; k++) begin
                m_step[k] = 0;
                m_err[k]  = 0;
                m_led[k]  = (m_sel < N) ? N'(1 << m_sel) : '0;
                m_cd      = 0;
                if (m_stab) begin
                    if (m_pv[k]) begin
                        m_d = (pos_of(m_s2) - pos_of(m_prev[k]) + 4) % 4;
                        if (m_d == 2) begin
                            m_err[k] = 1; m_acc[k] = 0;
                        end else if (m_d == 1) m_acc[k]++;
                        else if (m_d == 3) m_acc[k]--;
                        if (m_acc[k] == QD[k]) begin m_cd = 1; m_acc[k] = 0; end
                        if (m_acc[k] == -QD[k]) begin m_cd = -1; m_acc[k] = 0; end
                    end
                    m_pv[k]   = 1;
                    m_prev[k] = m_s2;
                end
                if (m_tick && CLR) begin
                    m_acc[k] = 0;
                    if (m_sel < N) m_val[k][m_sel] = 0;
                end else if (m_cd != 0 && m_sel < N) begin
                    if (SAT[k] != 0) begin
                        m_nv = m_val[k][m_sel] + m_cd;
                        if (m_nv < 0) m_nv = 0;
                        if (m_nv > 15) m_nv = 15;
                    end else begin
                        m_nv = (m_val[k][m_sel] + m_cd + 16) % 16;
                    end
                    m_step[k] = (m_nv != m_val[k][m_sel]);
                    m_dir[k]  = (m_cd > 0);
                    m_val[k][m_sel] = m_nv;
                end
            end
        end
    end

    // Per-cycle compare against the model
    logic [N*W-1:0] ev;
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            for (int k = 0; k < ND; k++) begin
                for (int j = 0; j < N; j++) ev[j*W +: W] = W'(m_val[k][j]);
                chk($sformatf("values[%0d]", k), 32'(dv[k]), 32'(ev));
                chk($sformatf("step[%0d]", k), 32'(dstep[k]), 32'(m_step[k]));
                chk($sformatf("dir_up[%0d]", k), 32'(ddir[k]), 32'(m_dir[k]));
                chk($sformatf("enc_err[%0d]", k), 32'(derr[k]), 32'(m_err[k]));
                chk($sformatf("led_sel[%0d]", k), 32'(dled[k]), 32'(m_led[k]));
            end
        end
    end

    int nstep [ND] = '{0, 0, 0};
    int nerr  [ND] = '{0, 0, 0};
    initial forever begin
        @(negedge CLK);
        for (int k = 0; k < ND; k++) begin
            if (dstep[k] === 1'b1) nstep[k]++;
            if (derr[k] === 1'b1) nerr[k]++;
        end
    end

    int pos_b = 0;

    task automatic hold(input logic [1:0] v, input int ticks);
        ENCODER = v;
        repeat (ticks * SD) @(negedge CLK);
    endtask

    task automatic cw();
        pos_b = (pos_b + 1) % 4;
        hold(code_of(pos_b), 3);
    endtask

    task automatic ccw();
        pos_b = (pos_b + 3) % 4;
        hold(code_of(pos_b), 3);
    endtask

    task automatic settle();
        #1;
    endtask

    int n0, n1, n2;
    logic [N*W-1:0] snap;

    initial begin
        @(negedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        settle();
        chk("rst_values", 32'(dv[0]), 32'h0);
        chk("rst_step", 32'(dstep[0]), 32'h0);
        chk("rst_dir", 32'(ddir[0]), 32'h0);
        chk("rst_err", 32'(derr[0]), 32'h0);
        chk("rst_led", 32'(dled[0]), 32'h0);
        RST = 1'b0;

        // Basic clockwise detents on register 1
        hold(2'b00, 3);
        repeat (4) cw();
        settle();
        chk("t1_q1_reg1", 32'(dv[0][7:4]), 32'd4);
        chk("t1_q1_steps", 32'(nstep[0]), 32'd4);
        chk("t1_q1_dir", 32'(ddir[0]), 32'd1);
        chk("t1_q1_reg0_reg2", 32'({dv[0][11:8], dv[0][3:0]}), 32'h0);
        chk("t1_q4_reg1", 32'(dv[1][7:4]), 32'd1);
        chk("t1_led", 32'(dled[0]), 32'b010);

        // QDIV=4: one detent per full cycle
        REG_SEL = 2'd0;
        n1 = nstep[1];
        repeat (4) cw();
        settle();
        chk("t2_q4_reg0_up", 32'(dv[1][3:0]), 32'd1);
        repeat (4) ccw();
        settle();
        chk("t2_q4_reg0_down", 32'(dv[1][3:0]), 32'd0);
        chk("t2_q4_steps", 32'(nstep[1] - n1), 32'd2);
        chk("t2_q4_dir", 32'(ddir[1]), 32'd0);

        // One-tick glitch is rejected; 2-position jump flags an error
        n0 = nstep[0]; snap = dv[0];
        hold(2'b01, 1);
        hold(2'b00, 3);
        settle();
        chk("t3_glitch_steps", 32'(nstep[0] - n0), 32'd0);
        chk("t3_glitch_values", 32'(dv[0]), 32'(snap));
        n0 = nerr[0];
        pos_b = 2;
        hold(2'b11, 3);
        settle();
        chk("t3_err_pulses", 32'(nerr[0] - n0), 32'd1);
        chk("t3_err_values", 32'(dv[0]), 32'(snap));

        // Wrap and saturate limits on register 2
        REG_SEL = 2'd2;
        n2 = nstep[2];
        ccw();
        settle();
        chk("t4_wrap_under", 32'(dv[0][11:8]), 32'd15);
        chk("t4_sat_floor", 32'(dv[2][11:8]), 32'd0);
        chk("t4_sat_floor_steps", 32'(nstep[2] - n2), 32'd0);
        cw();
        settle();
        chk("t4_wrap_over", 32'(dv[0][11:8]), 32'd0);
        repeat (15) cw();
        settle();
        chk("t4_sat_top", 32'(dv[2][11:8]), 32'd15);
        n2 = nstep[2];
        cw();
        settle();
        chk("t4_sat_ceiling", 32'(dv[2][11:8]), 32'd15);
        chk("t4_sat_ceiling_steps", 32'(nstep[2] - n2), 32'd0);
        chk("t4_sat_dir", 32'(ddir[2]), 32'd1);

        // Clear beats a coincident count; out-of-range select drops counts
        REG_SEL = 2'd0;
        repeat (7) cw();
        settle();
        chk("t5_reg0_seven", 32'(dv[0][3:0]), 32'd7);
        n0 = nstep[0];
        CLR = 1'b1;
        cw();
        CLR = 1'b0;
        settle();
        chk("t5_clr_reg0", 32'(dv[0][3:0]), 32'd0);
        chk("t5_clr_steps", 32'(nstep[0] - n0), 32'd0);
        REG_SEL = 2'd3;
        snap = dv[0]; n0 = nstep[0];
        cw();
        settle();
        chk("t5_sel3_values", 32'(dv[0]), 32'(snap));
        chk("t5_sel3_steps", 32'(nstep[0] - n0), 32'd0);
        chk("t5_sel3_led", 32'(dled[0]), 32'b000);

        // Reset mid-detent discards the partial cycle
        REG_SEL = 2'd0;
        cw();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        n1 = nstep[1];
        hold(code_of(pos_b), 3);
        repeat (3) cw();
        settle();
        chk("t6_q4_values", 32'(dv[1]), 32'h0);
        chk("t6_q4_steps", 32'(nstep[1] - n1), 32'd0);

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
